// File: rtl/tau_pkg.sv
// tau_pkg: shared types and constants for the tau core register file.
//   WORD_SIZE  default data width of registers and read/write-back words
//   reg_idx_t  register index R0..R7
//   b_sel_t    side-B select (0..7 register, 8 immediate, 9..15 not connected)
//   SEL_IMM8   side-B select value that returns the immediate operand
//   NUM_REGS   number of architectural registers
//   idx_to_onehot  decodes a register index into an 8-bit one-hot mask
package tau_pkg;

  localparam int WORD_SIZE = 8;
  localparam int NUM_REGS  = 8;

  typedef logic [2:0] reg_idx_t;
  typedef logic [3:0] b_sel_t;

  localparam b_sel_t SEL_IMM8 = 4'd8;

  function automatic logic [NUM_REGS-1:0] idx_to_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      mask[i] = (idx == i[2:0]);
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_commit_buf.sv
// wb_commit_buf: one-entry write-back commit buffer.
//   Holds a single accepted write-back word (sel/data) until it commits to the
//   register array. A commit and a new accept may happen in the same cycle:
//   the old word leaves as the new one is captured.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (drops the held word)
//   wb_valid     write-back word offered
//   wb_ready     buffer can accept (empty, or draining this cycle)
//   wb_sel       destination register index
//   wb_data      write-back word
//   freeze       holds the buffer; no commit while high
//   commit       the held word is written to the array at this edge
//   full         buffer holds a word
//   pend_sel     destination of the held word
//   pend_data    held word
//   pend_mask    one-hot destination of the held word, 0 when empty
module wb_commit_buf #(
  parameter int WORD_SIZE = tau_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  tau_pkg::reg_idx_t    wb_sel,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 freeze,
  output logic                 commit,
  output logic                 full,
  output tau_pkg::reg_idx_t    pend_sel,
  output logic [WORD_SIZE-1:0] pend_data,
  output logic [7:0]           pend_mask
);
  import tau_pkg::*;

  logic                 full_r;
  reg_idx_t             sel_r;
  logic [WORD_SIZE-1:0] data_r;
  logic                 accept_s;
  logic                 commit_s;

  // Handshake and commit qualification; ready ignores wb_valid by design.
  always_comb begin
    commit_s = full_r & ~freeze;
    wb_ready = ~full_r | ~freeze;
    accept_s = wb_valid & wb_ready;
  end

  // Buffer state: an accept always (re)fills, a lone commit empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      sel_r  <= 3'd0;
      data_r <= {WORD_SIZE{1'b0}};
    end else if (accept_s) begin
      full_r <= 1'b1;
      sel_r  <= wb_sel;
      data_r <= wb_data;
    end else if (commit_s) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  // Destination mask of the held word.
  always_comb begin
    if (full_r) begin
      pend_mask = idx_to_onehot(sel_r);
    end else begin
      pend_mask = 8'h00;
    end
  end

  assign commit    = commit_s;
  assign full      = full_r;
  assign pend_sel  = sel_r;
  assign pend_data = data_r;

endmodule

// File: rtl/register_file_wb.sv
// register_file_wb: architectural register file R0..R7 with a one-entry
// write-back commit buffer and two combinational read ports.
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : reads matching the held word return it (forwarding), rd_hazard = 0
//   undefined : reads return the array value, rd_hazard flags a pending match
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   wb_valid/wb_ready     write-back handshake; wb_sel/wb_data destination and word
//   freeze                holds the commit buffer
//   rd_a_sel/rd_a_data    side-A read port (R0..R7)
//   rd_b_sel/rd_b_data    side-B read port (R0..R7, 8 = imm8, 9..15 = 0)
//   imm8                  immediate operand for side B
//   rd_hazard             a read port names the held destination (non-bypass build)
//   pend_mask             one-hot destination of the held word
//   commit_cnt            wrapping count of commits since reset
module register_file_wb #(
  parameter int WORD_SIZE = tau_pkg::WORD_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [2:0]           wb_sel,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 freeze,
  input  logic [2:0]           rd_a_sel,
  output logic [WORD_SIZE-1:0] rd_a_data,
  input  logic [3:0]           rd_b_sel,
  input  logic [WORD_SIZE-1:0] imm8,
  output logic [WORD_SIZE-1:0] rd_b_data,
  output logic                 rd_hazard,
  output logic [7:0]           pend_mask,
  output logic [CNT_WIDTH-1:0] commit_cnt
);
  import tau_pkg::*;

  logic [WORD_SIZE-1:0] regs_r [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 commit_s;
  logic                 full_s;
  reg_idx_t             pend_sel_s;
  logic [WORD_SIZE-1:0] pend_data_s;
  logic                 a_match_s;
  logic                 b_match_s;
  logic [WORD_SIZE-1:0] a_word_s;
  logic [WORD_SIZE-1:0] b_word_s;

  wb_commit_buf #(.WORD_SIZE(WORD_SIZE)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .freeze    (freeze),
    .commit    (commit_s),
    .full      (full_s),
    .pend_sel  (pend_sel_s),
    .pend_data (pend_data_s),
    .pend_mask (pend_mask)
  );

  // Register array: the held word lands here when it commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (commit_s) begin
      regs_r[pend_sel_s] <= pend_data_s;
    end else begin
      regs_r[pend_sel_s] <= regs_r[pend_sel_s];
    end
  end

  // Commit counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (commit_s) begin
      cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Read ports: side B only matches the buffer for register selects 0..7.
  always_comb begin
    a_match_s = full_s & (rd_a_sel == pend_sel_s);
    b_match_s = full_s & ~rd_b_sel[3] & (rd_b_sel[2:0] == pend_sel_s);
    a_word_s  = regs_r[rd_a_sel];
    b_word_s  = regs_r[rd_b_sel[2:0]];
`ifdef REGFILE_BYPASS_EN
    if (a_match_s) begin
      a_word_s = pend_data_s;
    end else begin
      a_word_s = regs_r[rd_a_sel];
    end
    if (b_match_s) begin
      b_word_s = pend_data_s;
    end else begin
      b_word_s = regs_r[rd_b_sel[2:0]];
    end
    rd_hazard = 1'b0;
`else
    rd_hazard = a_match_s | b_match_s;
`endif
    rd_a_data = a_word_s;
    if (rd_b_sel < SEL_IMM8) begin
      rd_b_data = b_word_s;
    end else if (rd_b_sel == SEL_IMM8) begin
      rd_b_data = imm8;
    end else begin
      rd_b_data = {WORD_SIZE{1'b0}};
    end
  end

  assign commit_cnt = cnt_r;

endmodule
